// File: rtl/game_frame_sequencer_pkg.sv
// Shared types and constants for the game frame sequencer: phase encoding,
// sequencer states, default raster limits and the phase transition rule.
package game_pkg;

  localparam int unsigned H_LAST_DEF = 799;
  localparam int unsigned V_LAST_DEF = 599;

  typedef enum logic [2:0] {
    LOGO  = 3'd0,
    IDLE  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_REQ  = 2'd1,
    SEQ_GAP  = 2'd2
  } seq_e;

  // game_over outranks a simultaneous button edge while playing
  function automatic phase_e next_phase(input phase_e cur,
                                        input logic   btn_edge,
                                        input logic   game_over,
                                        input logic   logo_done);
    phase_e nxt;
    nxt = cur;
    case (cur)
      LOGO:    if (logo_done) nxt = IDLE;
      IDLE:    if (btn_edge) nxt = PLAY;
      PLAY: begin
        if (game_over)     nxt = OVER;
        else if (btn_edge) nxt = PAUSE;
      end
      PAUSE:   if (btn_edge) nxt = PLAY;
      OVER:    if (btn_edge) nxt = IDLE;
      default: nxt = LOGO;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/game_frame_sequencer_if.sv
// Stage request/acknowledge bundle between the sequencer (master) and the
// per-frame update blocks (slave).
interface game_frame_sequencer_if #(
  parameter int unsigned NUM_STAGES = 3
);
  logic [NUM_STAGES-1:0] stage_req;
  logic [NUM_STAGES-1:0] stage_ack;

  modport master (output stage_req, input stage_ack);
  modport slave  (input stage_req, output stage_ack);
endinterface

// File: rtl/game_frame_sequencer_frame_tick_gen.sv
// Frame and action tick generator from the raster coordinates; shared with
// the accelerometer sampler.
module frame_tick_gen #(
  parameter int unsigned H_LAST            = 799,
  parameter int unsigned V_LAST            = 599,
  parameter int unsigned FRAMES_PER_ACTION = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_coord,
  input  logic [9:0]  v_coord,
  output logic        frame_tick,
  output logic        action_tick
);

  localparam logic [9:0] H_MATCH  = 10'(H_LAST);
  localparam logic [9:0] V_MATCH  = 10'(V_LAST);
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_ACTION - 1);

  logic       frame_tick_d, frame_tick_q;
  logic [7:0] cnt_d, cnt_q;
  logic       unused_h_msb;

  assign unused_h_msb = h_coord[10];

  always_comb begin
    frame_tick_d = (h_coord[9:0] == H_MATCH) && (v_coord == V_MATCH);
    cnt_d        = cnt_q;
    if (frame_tick_q) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      frame_tick_q <= frame_tick_d;
      cnt_q        <= cnt_d;
    end
  end

  assign frame_tick  = frame_tick_q;
  assign action_tick = frame_tick_q && (cnt_q == '0);

endmodule

// File: rtl/game_frame_sequencer.sv
// Game-phase FSM plus per-action stage sequencer, driven by frame/action
// ticks derived from the pixel counters.
module game_frame_sequencer
  import game_pkg::*;
#(
  parameter int unsigned H_LAST            = H_LAST_DEF,
  parameter int unsigned V_LAST            = V_LAST_DEF,
  parameter int unsigned FRAMES_PER_ACTION = 2,
  parameter int unsigned LOGO_FRAMES       = 180,
  parameter int unsigned NUM_STAGES        = 3
) (
  input  logic                          pixel_clk,
  input  logic                          rst_n,
  input  logic [10:0]                   h_coord,
  input  logic [9:0]                    v_coord,
  input  logic                          button_c,
  input  logic                          game_over_in,
  game_frame_sequencer_if.master        stg,
  output phase_e                        phase,
  output logic                          logo_active,
  output logic                          frame_tick,
  output logic                          action_tick,
  output logic                          game_reset,
  output logic                          overrun
);

  localparam int unsigned    LW        = $clog2(LOGO_FRAMES + 1);
  localparam logic [LW-1:0]  LOGO_LAST = LW'(LOGO_FRAMES - 1);
  localparam logic [LW-1:0]  LOGO_SAT  = LW'(LOGO_FRAMES);
  localparam int unsigned    IW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_STAGES - 1);

  frame_tick_gen #(
    .H_LAST            (H_LAST),
    .V_LAST            (V_LAST),
    .FRAMES_PER_ACTION (FRAMES_PER_ACTION)
  ) u_tick (
    .clk         (pixel_clk),
    .rst_n       (rst_n),
    .h_coord     (h_coord),
    .v_coord     (v_coord),
    .frame_tick  (frame_tick),
    .action_tick (action_tick)
  );

  phase_e        phase_d, phase_q;
  logic          game_reset_d, game_reset_q;
  logic [LW-1:0] logo_cnt_d, logo_cnt_q;
  logic          btn_q;
  logic          btn_edge;
  logic          logo_done;

  always_comb begin
    btn_edge     = button_c & ~btn_q;
    logo_done    = frame_tick && (logo_cnt_q == LOGO_LAST);
    phase_d      = next_phase(phase_q, btn_edge, game_over_in, logo_done);
    game_reset_d = (phase_q == IDLE) && (phase_d == PLAY);
    logo_cnt_d   = logo_cnt_q;
    if ((phase_q == LOGO) && frame_tick && (logo_cnt_q != LOGO_SAT)) begin
      logo_cnt_d = logo_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= LOGO;
      game_reset_q <= 1'b0;
      logo_cnt_q   <= '0;
      btn_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      game_reset_q <= game_reset_d;
      logo_cnt_q   <= logo_cnt_d;
      btn_q        <= button_c;
    end
  end

  seq_e                  seq_d, seq_q;
  logic [IW-1:0]         idx_d, idx_q;
  logic [NUM_STAGES-1:0] req_d, req_q;
  logic                  overrun_d, overrun_q;

  // A GAP cycle follows every ack, so each stage costs ack latency + 1.
  // Once started a sequence runs to completion regardless of phase.
  always_comb begin
    seq_d     = seq_q;
    idx_d     = idx_q;
    req_d     = '0;
    overrun_d = overrun_q | (action_tick && (seq_q != SEQ_IDLE));
    case (seq_q)
      SEQ_IDLE: begin
        if (action_tick && (phase_q == PLAY)) begin
          seq_d = SEQ_REQ;
          idx_d = '0;
          req_d = NUM_STAGES'(1);
        end
      end
      SEQ_REQ: begin
        if (stg.stage_ack[idx_q]) seq_d = SEQ_GAP;
        else                      req_d = NUM_STAGES'(1) << idx_q;
      end
      SEQ_GAP: begin
        if (idx_q == IDX_LAST) begin
          seq_d = SEQ_IDLE;
        end else begin
          seq_d = SEQ_REQ;
          idx_d = idx_q + IW'(1);
          req_d = NUM_STAGES'(1) << (idx_q + IW'(1));
        end
      end
      default: seq_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q     <= SEQ_IDLE;
      idx_q     <= '0;
      req_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      overrun_q <= overrun_d;
    end
  end

  assign stg.stage_req = req_q;
  assign phase         = phase_q;
  assign logo_active   = (phase_q == LOGO);
  assign game_reset    = game_reset_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Directed bench for game_frame_sequencer on a compressed 10x5 raster.
module tb_game_frame_sequencer;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        button_c;
  logic        game_over_in;
  logic        auto_ack;
  logic [2:0]  ack_man;
  phase_e      phase;
  logic        logo_active, frame_tick, action_tick, game_reset, overrun;
  int          vectors = 0;
  int          miscompares = 0;

  game_frame_sequencer_if #(.NUM_STAGES(3)) stg_if ();
  assign stg_if.stage_ack = auto_ack ? stg_if.stage_req : ack_man;

  always #14 clk = ~clk;

  game_frame_sequencer #(
    .H_LAST            (9),
    .V_LAST            (4),
    .FRAMES_PER_ACTION (2),
    .LOGO_FRAMES       (3),
    .NUM_STAGES        (3)
  ) dut (
    .pixel_clk    (clk),
    .rst_n        (rst_n),
    .h_coord      (h_coord),
    .v_coord      (v_coord),
    .button_c     (button_c),
    .game_over_in (game_over_in),
    .stg          (stg_if.master),
    .phase        (phase),
    .logo_active  (logo_active),
    .frame_tick   (frame_tick),
    .action_tick  (action_tick),
    .game_reset   (game_reset),
    .overrun      (overrun)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents the last pixel for one cycle; on return frame_tick is visible.
  task automatic frame_px(input logic [10:0] h = 11'd9);
    h_coord = h;
    v_coord = 10'd4;
    step();
    h_coord = '0;
    v_coord = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; button_c = 1'b0; game_over_in = 1'b0;
    auto_ack = 1'b0; ack_man = '0; h_coord = '0; v_coord = '0;
    step(3);
    chk("rst_phase",   32'(phase), 32'(LOGO));
    chk("rst_logo",    32'(logo_active), 1);
    chk("rst_req",     32'(stg_if.stage_req), 0);
    chk("rst_ft",      32'(frame_tick), 0);
    chk("rst_at",      32'(action_tick), 0);
    chk("rst_greset",  32'(game_reset), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    step();

    // Logo phase: three frames, button ignored
    frame_px();
    chk("f1_ft", 32'(frame_tick), 1);
    chk("f1_at", 32'(action_tick), 1);
    step();
    chk("f1_ft_pulse", 32'(frame_tick), 0);
    chk("f1_at_pulse", 32'(action_tick), 0);
    button_c = 1'b1; step();
    chk("logo_btn_ignored", 32'(phase), 32'(LOGO));
    button_c = 1'b0; step();
    frame_px();
    chk("f2_ft", 32'(frame_tick), 1);
    chk("f2_at", 32'(action_tick), 0);
    step();
    frame_px();
    chk("f3_at", 32'(action_tick), 1);
    chk("f3_still_logo", 32'(phase), 32'(LOGO));
    step();
    chk("logo_to_idle", 32'(phase), 32'(IDLE));
    chk("logo_active_low", 32'(logo_active), 0);

    // Start game
    button_c = 1'b1; step();
    chk("start_phase", 32'(phase), 32'(PLAY));
    chk("start_greset", 32'(game_reset), 1);
    step();
    chk("greset_pulse", 32'(game_reset), 0);
    chk("held_btn_no_pause", 32'(phase), 32'(PLAY));
    button_c = 1'b0; step();

    // Same-cycle acks
    auto_ack = 1'b1;
    frame_px();
    chk("f4_at", 32'(action_tick), 0);
    step();
    chk("f4_no_seq", 32'(stg_if.stage_req), 0);
    frame_px();
    chk("f5_at", 32'(action_tick), 1);
    chk("f5_req_before", 32'(stg_if.stage_req), 0);
    step(); chk("seq_s0", 32'(stg_if.stage_req), 3'b001);
    step(); chk("seq_g0", 32'(stg_if.stage_req), 3'b000);
    step(); chk("seq_s1", 32'(stg_if.stage_req), 3'b010);
    step(); chk("seq_g1", 32'(stg_if.stage_req), 3'b000);
    step(); chk("seq_s2", 32'(stg_if.stage_req), 3'b100);
    step(); chk("seq_g2", 32'(stg_if.stage_req), 3'b000);
    step(); chk("seq_done", 32'(stg_if.stage_req), 3'b000);
    chk("seq_no_overrun", 32'(overrun), 0);

    // Stage 1 ack delayed 5 cycles
    auto_ack = 1'b0; ack_man = '0;
    frame_px(); step();
    frame_px();
    chk("f7_at", 32'(action_tick), 1);
    step(); chk("dly_s0", 32'(stg_if.stage_req), 3'b001);
    ack_man = 3'b001; step(); chk("dly_g0", 32'(stg_if.stage_req), 3'b000);
    ack_man = 3'b000; step(); chk("dly_s1_c0", 32'(stg_if.stage_req), 3'b010);
    for (int i = 1; i <= 5; i++) begin
      step(); chk("dly_s1_hold", 32'(stg_if.stage_req), 3'b010);
    end
    ack_man = 3'b010; step(); chk("dly_s1_drop", 32'(stg_if.stage_req), 3'b000);
    ack_man = 3'b000; step(); chk("dly_s2", 32'(stg_if.stage_req), 3'b100);
    ack_man = 3'b100; step(); chk("dly_g2", 32'(stg_if.stage_req), 3'b000);
    ack_man = 3'b000; step(); chk("dly_done", 32'(stg_if.stage_req), 3'b000);

    // Overrun with stalled stage 0; non-matching ack bits ignored
    ack_man = 3'b110;
    frame_px(); step();
    frame_px(); step();
    chk("ovr_s0", 32'(stg_if.stage_req), 3'b001);
    frame_px(); step();
    chk("ovr_wrong_ack", 32'(stg_if.stage_req), 3'b001);
    chk("ovr_not_yet", 32'(overrun), 0);
    frame_px();
    chk("f11_at", 32'(action_tick), 1);
    step();
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_req_held", 32'(stg_if.stage_req), 3'b001);
    step(3);
    chk("ovr_sticky", 32'(overrun), 1);
    ack_man = 3'b001; step(); chk("ovr_g0", 32'(stg_if.stage_req), 3'b000);
    ack_man = 3'b000; step(); chk("ovr_s1", 32'(stg_if.stage_req), 3'b010);
    ack_man = 3'b010; step();
    ack_man = 3'b000; step(); chk("ovr_s2", 32'(stg_if.stage_req), 3'b100);
    ack_man = 3'b100; step();
    ack_man = 3'b000; step();
    chk("ovr_done", 32'(stg_if.stage_req), 3'b000);
    chk("ovr_still", 32'(overrun), 1);

    // Pause while stage 1 is requested
    frame_px(); step();
    frame_px(); step();
    chk("pz_s0", 32'(stg_if.stage_req), 3'b001);
    ack_man = 3'b001; step();
    ack_man = 3'b000; step(); chk("pz_s1", 32'(stg_if.stage_req), 3'b010);
    button_c = 1'b1; step();
    chk("pz_phase", 32'(phase), 32'(PAUSE));
    chk("pz_s1_kept", 32'(stg_if.stage_req), 3'b010);
    button_c = 1'b0; ack_man = 3'b010; step();
    chk("pz_g1", 32'(stg_if.stage_req), 3'b000);
    ack_man = 3'b000; step(); chk("pz_s2_finishes", 32'(stg_if.stage_req), 3'b100);
    ack_man = 3'b100; step();
    ack_man = 3'b000; step(); chk("pz_done", 32'(stg_if.stage_req), 3'b000);
    frame_px(); step();
    frame_px();
    chk("f15_at", 32'(action_tick), 1);
    step(); chk("pz_no_start", 32'(stg_if.stage_req), 3'b000);
    step(); chk("pz_no_start2", 32'(stg_if.stage_req), 3'b000);
    chk("pz_overrun_kept", 32'(overrun), 1);
    button_c = 1'b1; step();
    chk("resume_phase", 32'(phase), 32'(PLAY));
    chk("resume_no_greset", 32'(game_reset), 0);
    button_c = 1'b0; step();

    // game_over beats a simultaneous button edge
    game_over_in = 1'b1; button_c = 1'b1; step();
    chk("prio_over", 32'(phase), 32'(OVER));
    game_over_in = 1'b0; button_c = 1'b0; step();
    chk("over_hold", 32'(phase), 32'(OVER));
    button_c = 1'b1; step();
    chk("over_to_idle", 32'(phase), 32'(IDLE));
    button_c = 1'b0; step();

    // Async reset mid-sequence; h_coord[10] is ignored by the tick match
    button_c = 1'b1; step();
    chk("replay", 32'(phase), 32'(PLAY));
    button_c = 1'b0; step();
    frame_px(11'h409);
    chk("f16_h_msb_ignored", 32'(frame_tick), 1);
    chk("f16_at", 32'(action_tick), 0);
    step();
    frame_px(); step();
    chk("ar_s0", 32'(stg_if.stage_req), 3'b001);
    #5 rst_n = 1'b0;
    #1;
    chk("ar_req_drop", 32'(stg_if.stage_req), 3'b000);
    chk("ar_phase", 32'(phase), 32'(LOGO));
    chk("ar_overrun_clr", 32'(overrun), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
